// File: rtl/accum_operand_sequencer.sv
// Operand sequencer for an external accumulating multiplier: feeds one product per accepted
// beat, waits for the final product to land, then returns the captured sum and beat count.
module accum_operand_sequencer #(
  parameter int unsigned A_WIDTH   = 20,
  parameter int unsigned B_WIDTH   = 18,
  parameter int unsigned Z_WIDTH   = 38,
  parameter int unsigned LEN_WIDTH = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [A_WIDTH-1:0]   s_a,
  input  logic [B_WIDTH-1:0]   s_b,
  input  logic                 s_last,
  output logic [A_WIDTH-1:0]   acc_a,
  output logic [B_WIDTH-1:0]   acc_b,
  output logic                 acc_clr,
  input  logic [Z_WIDTH-1:0]   acc_z,
  output logic                 r_valid,
  input  logic                 r_ready,
  output logic [Z_WIDTH-1:0]   r_data,
  output logic [LEN_WIDTH-1:0] r_count,
  output logic                 r_sat
);

  typedef enum logic [2:0] {
    CLR   = 3'd0,
    RUN   = 3'd1,
    FLUSH = 3'd2,
    DRAIN = 3'd3,
    OUT   = 3'd4
  } state_t;

  localparam logic [LEN_WIDTH-1:0] CNT_MAX = '1;

  state_t               state;
  logic [LEN_WIDTH-1:0] count;

  // Handshake and clear strobes are pure decodes of the state register.
  assign s_ready = (state == RUN);
  assign r_valid = (state == OUT);
  assign acc_clr = (state == CLR);

  // Sequencer FSM with registered operand and result outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= CLR;
      count   <= '0;
      acc_a   <= '0;
      acc_b   <= '0;
      r_data  <= '0;
      r_count <= '0;
      r_sat   <= 1'b0;
    end else begin
      case (state)
        CLR: begin
          count <= '0;
          r_sat <= 1'b0;
          acc_a <= '0;
          acc_b <= '0;
          state <= RUN;
        end
        RUN: begin
          if (s_valid) begin
            acc_a <= s_a;
            acc_b <= s_b;
            if (count == CNT_MAX) begin
              r_sat <= 1'b1;
            end else begin
              count <= count + LEN_WIDTH'(1);
            end
            if (s_last) begin
              state <= FLUSH;
            end
          end else begin
            // Idle cycles must contribute nothing to the running sum.
            acc_a <= '0;
            acc_b <= '0;
          end
        end
        FLUSH: begin
          acc_a <= '0;
          acc_b <= '0;
          state <= DRAIN;
        end
        DRAIN: begin
          r_data  <= acc_z;
          r_count <= count;
          state   <= OUT;
        end
        OUT: begin
          if (r_ready) begin
            state <= CLR;
          end
        end
        default: begin
          state <= CLR;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_accum_operand_sequencer.sv
// Bench for accum_operand_sequencer: two instances (10-bit and 2-bit count) share stimulus,
// each driving its own accumulator model; results are checked against a scoreboard queue.
module tb_accum_operand_sequencer;

  localparam int unsigned AW = 20;
  localparam int unsigned BW = 18;
  localparam int unsigned ZW = 38;

  typedef struct {
    logic [ZW-1:0] data;
    int            n;
  } exp_t;

  logic          clk;
  logic          reset;
  logic          s_valid;
  logic [AW-1:0] s_a;
  logic [BW-1:0] s_b;
  logic          s_last;
  logic          r_ready;

  logic          s_ready1, acc_clr1, r_valid1, r_sat1;
  logic [AW-1:0] acc_a1;
  logic [BW-1:0] acc_b1;
  logic [ZW-1:0] acc_z1, r_data1;
  logic [9:0]    r_count1;

  logic          s_ready2, acc_clr2, r_valid2, r_sat2;
  logic [AW-1:0] acc_a2;
  logic [BW-1:0] acc_b2;
  logic [ZW-1:0] acc_z2, r_data2;
  logic [1:0]    r_count2;

  int   n_checks;
  int   n_fail;
  int   n_results;
  int   n_frames;
  exp_t sb[$];
  logic [AW-1:0] fa[$];
  logic [BW-1:0] fb[$];

  accum_operand_sequencer #(.A_WIDTH(AW), .B_WIDTH(BW), .Z_WIDTH(ZW), .LEN_WIDTH(10)) dut1 (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready1), .s_a(s_a), .s_b(s_b),
    .s_last(s_last), .acc_a(acc_a1), .acc_b(acc_b1), .acc_clr(acc_clr1), .acc_z(acc_z1),
    .r_valid(r_valid1), .r_ready(r_ready), .r_data(r_data1), .r_count(r_count1), .r_sat(r_sat1)
  );

  accum_operand_sequencer #(.A_WIDTH(AW), .B_WIDTH(BW), .Z_WIDTH(ZW), .LEN_WIDTH(2)) dut2 (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready2), .s_a(s_a), .s_b(s_b),
    .s_last(s_last), .acc_a(acc_a2), .acc_b(acc_b2), .acc_clr(acc_clr2), .acc_z(acc_z2),
    .r_valid(r_valid2), .r_ready(r_ready), .r_data(r_data2), .r_count(r_count2), .r_sat(r_sat2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Accumulating multiplier models, wrapping modulo 2^ZW.
  always_ff @(posedge clk) begin
    acc_z1 <= acc_clr1 ? '0 : acc_z1 + ({18'b0, acc_a1} * {20'b0, acc_b1});
    acc_z2 <= acc_clr2 ? '0 : acc_z2 + ({18'b0, acc_a2} * {20'b0, acc_b2});
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Drive one beat from a negedge; returns at the negedge after it is accepted.
  task automatic send_beat(input logic [AW-1:0] a, input logic [BW-1:0] b, input logic last);
    int waited = 0;
    s_valid = 1'b1;
    s_a     = a;
    s_b     = b;
    s_last  = last;
    while (!s_ready1 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    check_val("s_ready_wait", 64'(s_ready1), 64'd1);
    @(posedge clk);
    @(negedge clk);
    s_valid = 1'b0;
    s_a     = '0;
    s_b     = '0;
    s_last  = 1'b0;
  endtask

  task automatic send_frame(input int max_gap);
    exp_t        e;
    logic [63:0] sum = '0;
    foreach (fa[i]) sum += 64'(fa[i]) * 64'(fb[i]);
    e.data = sum[ZW-1:0];
    e.n    = fa.size();
    sb.push_back(e);
    n_frames++;
    foreach (fa[i]) begin
      if (max_gap > 0) repeat ($urandom_range(0, max_gap)) @(negedge clk);
      send_beat(fa[i], fb[i], (i == fa.size() - 1));
    end
  endtask

  task automatic wait_idle();
    int k = 0;
    while (sb.size() != 0 && k < 300) begin
      @(negedge clk);
      k++;
    end
    check_val("sb_drained", 64'(sb.size()), 64'd0);
    @(negedge clk);
  endtask

  // Result monitor: checks every valid cycle (covers backpressure stability), pops on handshake.
  always begin
    @(negedge clk);
    #1;
    if (reset && r_valid1) begin
      check_val("r_valid2", 64'(r_valid2), 64'd1);
      check_val("s_ready_out", 64'(s_ready1 | s_ready2), 64'd0);
      if (sb.size() == 0) begin
        check_val("unexpected_result", 64'(sb.size()), 64'd1);
      end else begin
        check_val("r_data1", 64'(r_data1), 64'(sb[0].data));
        check_val("r_data2", 64'(r_data2), 64'(sb[0].data));
        check_val("r_count1", 64'(r_count1), 64'((sb[0].n > 1023) ? 1023 : sb[0].n));
        check_val("r_sat1", 64'(r_sat1), 64'(sb[0].n > 1023));
        check_val("r_count2", 64'(r_count2), 64'((sb[0].n > 3) ? 3 : sb[0].n));
        check_val("r_sat2", 64'(r_sat2), 64'(sb[0].n > 3));
        if (r_ready) begin
          void'(sb.pop_front());
          n_results++;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    n_checks = 0; n_fail = 0; n_results = 0; n_frames = 0;
    reset = 1'b0; s_valid = 1'b0; s_a = '0; s_b = '0; s_last = 1'b0; r_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_val("rst_acc_clr", 64'(acc_clr1), 64'd1);
    check_val("rst_s_ready", 64'(s_ready1), 64'd0);
    check_val("rst_r_valid", 64'(r_valid1), 64'd0);
    check_val("rst_acc_a", 64'(acc_a1), 64'd0);
    check_val("rst_acc_b", 64'(acc_b1), 64'd0);
    check_val("rst_r_data", 64'(r_data1), 64'd0);
    check_val("rst_r_count", 64'(r_count1), 64'd0);
    check_val("rst_r_sat", 64'(r_sat1), 64'd0);
    reset = 1'b1;
    #1;
    check_val("clr_cycle_acc_clr", 64'(acc_clr1), 64'd1);
    check_val("clr_cycle_s_ready", 64'(s_ready1), 64'd0);
    @(negedge clk);
    check_val("run_acc_clr", 64'(acc_clr1), 64'd0);
    check_val("run_s_ready", 64'(s_ready1), 64'd1);

    // Single maximal beat, with latency and flush checks.
    fa = '{20'h7FFFF}; fb = '{18'h1FFFF};
    send_frame(0);
    check_val("flush_acc_a", 64'(acc_a1), 64'h7FFFF);
    check_val("flush_r_valid", 64'(r_valid1), 64'd0);
    @(negedge clk);
    check_val("drain_acc_a", 64'(acc_a1), 64'd0);
    check_val("drain_r_valid", 64'(r_valid1), 64'd0);
    @(negedge clk);
    check_val("out_r_valid", 64'(r_valid1), 64'd1);
    check_val("single_r_data", 64'(r_data1), 64'd68718821377);
    wait_idle();

    // Three-beat frame back to back, then with random gaps.
    fa = '{20'd2, 20'd4, 20'd6}; fb = '{18'd3, 18'd5, 18'd7};
    send_frame(0);
    wait_idle();
    for (int rep = 0; rep < 3; rep++) begin
      send_frame(3);
      wait_idle();
    end

    // Backpressure on the result.
    r_ready = 1'b0;
    send_frame(0);
    k = 0;
    while (!r_valid1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    check_val("bp_r_valid", 64'(r_valid1), 64'd1);
    repeat (5) @(negedge clk);
    check_val("bp_r_data", 64'(r_data1), 64'd68);
    r_ready = 1'b1;
    wait_idle();
    fa = '{20'd1}; fb = '{18'd1};
    send_frame(0);
    wait_idle();

    // Reset mid-frame discards the partial sum.
    send_beat(20'd100, 18'd100, 1'b0);
    send_beat(20'd100, 18'd100, 1'b0);
    reset = 1'b0;
    #1;
    check_val("midrst_acc_clr", 64'(acc_clr1), 64'd1);
    check_val("midrst_s_ready", 64'(s_ready1), 64'd0);
    check_val("midrst_acc_a", 64'(acc_a1), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    send_frame(0);
    wait_idle();

    // Wrapping sum, then count saturation on the narrow instance.
    fa = '{20'h7FFFF, 20'h7FFFF, 20'h7FFFF, 20'h7FFFF, 20'h7FFFF};
    fb = '{18'h1FFFF, 18'h1FFFF, 18'h1FFFF, 18'h1FFFF, 18'h1FFFF};
    send_frame(0);
    wait_idle();
    fa = '{20'd1, 20'd1, 20'd1, 20'd1, 20'd1};
    fb = '{18'd1, 18'd1, 18'd1, 18'd1, 18'd1};
    send_frame(1);
    wait_idle();

    check_val("result_count", 64'(n_results), 64'(n_frames));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/accum_operand_sequencer.md
# accum_operand_sequencer

Initiator-side companion to the accumulating multiplier (`z_out = z_out + a*b`, output not registered beyond the accumulator register). It accepts a framed operand stream over a valid/ready handshake and drives the accumulator's `a`, `b` and clear inputs one product per accepted beat. After the frame's last beat it waits for the final product to land, captures the accumulator output, and presents it as a single result beat together with the product count. After the result is taken it clears the accumulator for the next frame.

## Interface
- A_WIDTH, 20, operand a width (unsigned)
- B_WIDTH, 18, operand b width (unsigned)
- Z_WIDTH, 38, accumulator width; must equal A_WIDTH+B_WIDTH
- LEN_WIDTH, 10, product-count width
- clk  input  1  single clock; all logic on rising edge
- reset  input  1  asynchronous, active-low reset
- s_valid  input  1  operand beat valid
- s_ready  output  1  operand beat accepted when s_valid && s_ready
- s_a  input  A_WIDTH  operand a
- s_b  input  B_WIDTH  operand b
- s_last  input  1  marks the final beat of a frame
- acc_a  output  A_WIDTH  to accumulator `a`; registered
- acc_b  output  B_WIDTH  to accumulator `b`; registered
- acc_clr  output  1  to accumulator reset/clear; active-high, decoded from state
- acc_z  input  Z_WIDTH  accumulator `z_out`
- r_valid  output  1  result valid
- r_ready  input  1  result accepted when r_valid && r_ready
- r_data  output  Z_WIDTH  captured accumulator sum
- r_count  output  LEN_WIDTH  number of beats in the frame (saturating)
- r_sat  output  1  r_count saturated during the frame

## Operation
- Accumulator contract: on each clk edge it does z <= 0 if acc_clr, else z <= z + acc_a*acc_b. It wraps modulo 2^Z_WIDTH. The sequencer performs no arithmetic on acc_z; it captures it verbatim.
- FSM states: CLR, RUN, FLUSH, DRAIN, OUT.
- CLR: acc_clr=1, s_ready=0. Next state is RUN. Resets the count register and r_sat.
- RUN: s_ready=1. On acceptance:
  - load acc_a/acc_b from s_a/s_b
  - increment the count, saturating at 2^LEN_WIDTH-1
  - set r_sat if the count was already at max
  - if s_last, go to FLUSH
  - With no acceptance, acc_a/acc_b are loaded with 0, so the accumulator adds zero on idle cycles.
- FLUSH: s_ready=0. acc_a/acc_b still hold the last operand, which the accumulator adds at the end of this cycle. acc_a/acc_b are zeroed at the exiting edge. Next state is DRAIN.
- DRAIN: acc_z is final. r_data <= acc_z and r_count <= count at the exiting edge. Next state is OUT.
- OUT: r_valid=1, s_ready=0, acc_a=acc_b=0. On r_valid && r_ready, go to CLR.
- Backpressure: r_data, r_count and r_sat are stable while r_valid && !r_ready.
- A frame of one beat (s_last on the first beat) is legal.
- A frame always has at least one beat; there is no empty-frame path.

## Timing
- Reset values (asynchronous, while reset=0):
  - state = CLR, so acc_clr=1 during reset
  - acc_a=0, acc_b=0, s_ready=0, r_valid=0, r_data=0, r_count=0, r_sat=0
- First cycle after reset release: CLR, one cycle with acc_clr=1. s_ready rises in the following cycle.
- Throughput: one beat per cycle in RUN.
- Latency: last beat accepted at edge E.
  - FLUSH spans E..E+1.
  - DRAIN spans E+1..E+2.
  - r_valid=1 from edge E+2.
- Turnaround: result accepted at edge R gives CLR in R..R+1, and s_ready=1 from R+1.
- Reset mid-frame (any state): returns to CLR immediately. The partial sum is discarded because the accumulator is cleared via acc_clr. No result is emitted.
- s_valid is ignored outside RUN; s_a, s_b and s_last are don't-care when s_valid=0.

## Test plan
- Single beat a=20'h7FFFF, b=18'h1FFFF with s_last=1 -> r_data=68718821377, r_count=1, r_sat=0; r_valid rises 2 edges after acceptance.
- Frame (2,3),(4,5),(6,7) with 0-3 cycle s_valid gaps between beats -> r_data=68, r_count=3, identical to the back-to-back case.
- Same frame with r_ready held low 5 cycles -> r_valid, r_data=68 and r_count=3 stable throughout, s_ready=0. Next frame (1,1) after acceptance -> r_data=1, confirming the clear.
- Reset asserted after 2 beats of (100,100), then frame (1,1) -> acc_clr=1 during reset, result r_data=1, r_count=1.
- Five beats of (20'h7FFFF, 18'h1FFFF) -> r_data=68716199941 (wrapped mod 2^38), r_count=5.
- LEN_WIDTH=2, five beats of (1,1) -> r_data=5, r_count=3, r_sat=1.
